mips_pc_unit: RTL
=================

MIPS_PC_UNIT -- requirements
Module: mips_pc_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of all address ports and registers.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded by reset.
REQ-003 Parameter EXC_VECTOR, default 32'h8000_0180: PC value loaded on exception or misaligned redirect.
REQ-004 Parameter STEP, default 4: sequential PC increment.
REQ-005 Parameter ALIGN_BITS, default 2: number of low target bits that must be zero.
REQ-006 Parameter CNT_WIDTH, default 16: width of FetchCount.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 ClockPulse  in  1  clock; all state updates on its rising edge.
REQ-009 ResetN  in  1  asynchronous active-low reset.
REQ-010 Stall  in  1  hold PC; suppress fetch request.
REQ-011 FetchReady  in  1  instruction memory accepts CurrentInstructionAddress this cycle.
REQ-012 FetchValid  out  1  CurrentInstructionAddress is a valid fetch request.
REQ-013 CurrentInstructionAddress  out  ADDR_WIDTH  registered PC.
REQ-014 BranchTaken / BranchTarget  in  1 / ADDR_WIDTH  resolved taken branch and its target.
REQ-015 JumpValid / JumpTarget  in  1 / ADDR_WIDTH  jump request and its target.
REQ-016 Exception  in  1  synchronous exception request.
REQ-017 Eret  in  1  return from exception.
REQ-018 Epc  out  ADDR_WIDTH  registered exception PC.
REQ-019 AddrErr  out  1  one-cycle pulse: misaligned redirect was trapped.
REQ-020 FetchCount  out  CNT_WIDTH  count of accepted fetches.

Function
REQ-021 FetchValid SHALL be the registered Running flag AND NOT Stall; Running SHALL be 0 in reset and 1 from the first rising edge after ResetN deasserts.
REQ-022 A fetch SHALL be accepted on a rising edge when FetchValid and FetchReady are both 1.
REQ-023 Next-PC priority per edge, highest first: Exception, Eret, BranchTaken, JumpValid, accepted fetch, hold.
REQ-024 Exception: PC <= EXC_VECTOR; Epc <= CurrentInstructionAddress; all lower-priority requests that cycle ignored.
REQ-025 Eret (no Exception): PC <= Epc; Epc unchanged.
REQ-026 Branch/Jump redirect with target[ALIGN_BITS-1:0] == 0: PC <= target.
REQ-027 Branch/Jump redirect with misaligned target: PC <= EXC_VECTOR; Epc <= target; AddrErr = 1 for exactly the next cycle.
REQ-028 Redirects (REQ-024..027) SHALL take effect regardless of Stall and FetchReady; an outstanding unaccepted request is abandoned.
REQ-029 Accepted fetch with no redirect: PC <= PC + STEP, modulo 2^ADDR_WIDTH (wraps to 0, no flag).
REQ-030 Hold: when FetchValid=1 and FetchReady=0 and no redirect, CurrentInstructionAddress SHALL remain stable.
REQ-031 Stall=1 with no redirect SHALL hold PC, Epc, FetchCount.
REQ-032 FetchCount SHALL increment by 1 per accepted fetch, including on the edge where a redirect overrides the increment; it SHALL wrap to 0 at 2^CNT_WIDTH.
REQ-033 AddrErr SHALL be 0 in every cycle not immediately following a trapped misaligned redirect.
REQ-034 Exception and Eret asserted together: Exception wins; Epc captures current PC.

Reset
REQ-035 While ResetN=0: CurrentInstructionAddress = RESET_VECTOR, Epc = 0, FetchCount = 0, AddrErr = 0, Running = 0, FetchValid = 0, asynchronously.
REQ-036 Reset asserted mid-operation (including with a pending unaccepted request or redirect) SHALL override all state immediately; no request survives reset.
REQ-037 First fetch after reset release SHALL present RESET_VECTOR with FetchValid=1 one edge after ResetN rises.

Verification
REQ-038 Reset release, FetchReady=1 for 4 cycles -> addresses 0x0,0x4,0x8,0xC; FetchCount=4.
REQ-039 PC=0x10, FetchReady=0 for 3 cycles then 1 -> address held at 0x10 for 3 cycles, then 0x14; Stall=1 one cycle -> FetchValid=0, PC held.
REQ-040 PC=0x20, BranchTaken=1 target 0x100 with JumpValid=1 target 0x200 same cycle -> PC=0x100; Exception same cycle instead -> PC=0x80000180, Epc=0x20.
REQ-041 JumpValid=1 target 0x202 -> PC=0x80000180, Epc=0x202, AddrErr high exactly one cycle; then Eret -> PC=0x202.
REQ-042 PC=0xFFFFFFFC accepted fetch -> PC=0x0; FetchCount at 0xFFFF plus one accept -> 0x0000.
REQ-043 ResetN low mid-stall with pending Exception -> PC=0x0, Epc=0, FetchValid=0 immediately, before next clock edge.

Source files
------------

// File: rtl/mips_pc_unit.sv
// rtl/mips_pc_unit.sv - MIPS program counter with fetch handshake, redirects, exceptions and fetch counter
module mips_pc_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int                    STEP         = 4,
  parameter int                    ALIGN_BITS   = 2,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                  ClockPulse,
  input  logic                  ResetN,
  input  logic                  Stall,
  input  logic                  FetchReady,
  output logic                  FetchValid,
  output logic [ADDR_WIDTH-1:0] CurrentInstructionAddress,
  input  logic                  BranchTaken,
  input  logic [ADDR_WIDTH-1:0] BranchTarget,
  input  logic                  JumpValid,
  input  logic [ADDR_WIDTH-1:0] JumpTarget,
  input  logic                  Exception,
  input  logic                  Eret,
  output logic [ADDR_WIDTH-1:0] Epc,
  output logic                  AddrErr,
  output logic [CNT_WIDTH-1:0]  FetchCount
);

  // Low target bits that must be zero for a legal redirect.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic                  running;
  logic                  accept;
  logic                  redirect_req;
  logic [ADDR_WIDTH-1:0] redirect_tgt;
  logic                  misaligned;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] epc_next;
  logic                  addr_err_next;

  assign FetchValid = running & ~Stall;
  assign accept     = FetchValid & FetchReady;

  // Select the branch/jump target (branch has priority) and check its alignment.
  always_comb begin
    redirect_req = BranchTaken | JumpValid;
    redirect_tgt = BranchTaken ? BranchTarget : JumpTarget;
    misaligned   = |(redirect_tgt & ALIGN_MASK);
  end

  // Next PC/EPC by priority: exception, eret, branch/jump, accepted fetch, hold.
  always_comb begin
    pc_next       = CurrentInstructionAddress;
    epc_next      = Epc;
    addr_err_next = 1'b0;
    if (Exception) begin
      pc_next  = EXC_VECTOR;
      epc_next = CurrentInstructionAddress;
    end else if (Eret) begin
      pc_next = Epc;
    end else if (redirect_req) begin
      if (misaligned) begin
        pc_next       = EXC_VECTOR;
        epc_next      = redirect_tgt;
        addr_err_next = 1'b1;
      end else begin
        pc_next = redirect_tgt;
      end
    end else if (accept) begin
      pc_next = CurrentInstructionAddress + ADDR_WIDTH'(STEP);
    end
  end

  // State registers; the fetch counter counts accepts even when a redirect overrides the PC step.
  always_ff @(posedge ClockPulse or negedge ResetN) begin
    if (!ResetN) begin
      running                   <= 1'b0;
      CurrentInstructionAddress <= RESET_VECTOR;
      Epc                       <= '0;
      AddrErr                   <= 1'b0;
      FetchCount                <= '0;
    end else begin
      running                   <= 1'b1;
      CurrentInstructionAddress <= pc_next;
      Epc                       <= epc_next;
      AddrErr                   <= addr_err_next;
      if (accept) begin
        FetchCount <= FetchCount + CNT_WIDTH'(1);
      end
    end
  end

endmodule
